// File: rtl/spi_target_pkg.sv
// spi_target_pkg: shared definitions for the mode-0 SPI target.
// Holds the FSM state encoding, synchroniser depth, default idle byte
// and the bit-counter width.
package spi_target_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAITHI = 2'd2
    } state_t;

    localparam int         SPI_SYNC_STAGES  = 2;
    localparam logic [7:0] IDLEBYTE_DEFAULT = 8'hFF;
    localparam int         BITCNT_W         = 3;

endpackage

// File: rtl/spi_target_txfifo.sv
// spi_target_txfifo: circular TX byte FIFO, DEPTH a power of two.
// Full/empty are judged on the count at cycle start, so a push into a
// full FIFO is dropped even when a pop happens in the same cycle, and a
// pop from an empty FIFO does nothing while a concurrent push still lands.
module spi_target_txfifo
    import spi_target_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok, pop_ok;

    // Accept push/pop against the start-of-cycle occupancy and advance pointers.
    always_comb begin
        push_ok  = push && (count_q != FULL_CNT);
        pop_ok   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
        full  = (count_q == FULL_CNT);
        empty = (count_q == '0);
        dout  = mem_q[rd_ptr_q];
    end

    // Pointer/count registers with reset; storage array is data only.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/spi_target.sv
// spi_target: mode-0 SPI target (responder), pins oversampled on CLK.
// Build option SPI_TARGET_TXFIFO_EN: when defined, TX bytes queue in a
// TXDEPTH-entry FIFO; otherwise a single holding register is used.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int         TXDEPTH  = 4,
    parameter logic [7:0] IDLEBYTE = IDLEBYTE_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCK,
    input  logic       MOSI,
    input  logic       nSS,
    output logic       MISO,
    output logic       MISO_OE,
    input  logic [7:0] TXD,
    input  logic       TXWR,
    output logic       TXFULL,
    output logic       TXEMPTY,
    output logic [7:0] RXD,
    output logic       RXVALID,
    input  logic       RXRD,
    output logic       OVR,
    output logic       UNR,
    output logic       BUSY
);
    localparam int S = SPI_SYNC_STAGES;

    // [0..S-1] synchroniser, [S] edge-detect history
    logic [S:0]          sck_sync_q, sck_sync_d;
    logic [S:0]          nss_sync_q, nss_sync_d;
    logic [S-1:0]        mosi_sync_q, mosi_sync_d;
    logic                sck_rise, sck_fall, nss_s, nss_fall, nss_rise, mosi_s;

    state_t              state_q, state_d;
    logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [6:0]          shift_rx_q, shift_rx_d;
    logic [7:0]          shift_tx_q, shift_tx_d;
    logic                miso_q, miso_oe_q, miso_oe_d;
    logic [7:0]          rxd_q, rxd_d;
    logic                rxvalid_q, rxvalid_d, ovr_q, ovr_d, unr_q, unr_d;
    logic                busy_q, busy_d;
    logic                load_tx, byte_done, tx_pop;
    logic [7:0]          tx_head;
    logic                tx_empty, tx_full;

`ifdef SPI_TARGET_TXFIFO_EN
    spi_target_txfifo #(
        .DEPTH (TXDEPTH)
    ) u_txfifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (TXWR),
        .pop   (tx_pop),
        .din   (TXD),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );
`else
    logic [7:0] hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;
    logic       unused_txdepth;

    assign unused_txdepth = ^TXDEPTH;

    // Single-entry holding register: same full-at-cycle-start rule as the FIFO.
    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        if (tx_pop && hold_vld_q) begin
            hold_vld_d = 1'b0;
        end
        if (TXWR && !hold_vld_q) begin
            hold_d     = TXD;
            hold_vld_d = 1'b1;
        end
        tx_head  = hold_q;
        tx_empty = !hold_vld_q;
        tx_full  = hold_vld_q;
    end

    // Holding register state; only the valid flag needs reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_vld_q <= 1'b0;
        end else begin
            hold_vld_q <= hold_vld_d;
        end
        hold_q <= hold_d;
    end
`endif

    // Synchroniser shift and edge extraction from the synced/history pair.
    always_comb begin
        sck_sync_d  = {sck_sync_q[S-1:0], SCK};
        nss_sync_d  = {nss_sync_q[S-1:0], nSS};
        mosi_sync_d = {mosi_sync_q[S-2:0], MOSI};
        sck_rise    = sck_sync_q[S-1] && !sck_sync_q[S];
        sck_fall    = !sck_sync_q[S-1] && sck_sync_q[S];
        nss_s       = nss_sync_q[S-1];
        nss_fall    = !nss_s && nss_sync_q[S];
        nss_rise    = nss_s && !nss_sync_q[S];
        mosi_s      = mosi_sync_q[S-1];
    end

    // FSM, shifters, TX reload and RX hand-off next-state logic.
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_rx_d = shift_rx_q;
        shift_tx_d = shift_tx_q;
        miso_oe_d  = miso_oe_q;
        rxd_d      = rxd_q;
        rxvalid_d  = rxvalid_q;
        ovr_d      = ovr_q;
        unr_d      = unr_q;
        load_tx    = 1'b0;
        byte_done  = 1'b0;
        tx_pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (nss_fall) begin
                    state_d   = ST_ACTIVE;
                    bitcnt_d  = '0;
                    load_tx   = 1'b1;
                    miso_oe_d = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (nss_rise) begin
                    // Partial RX/TX bytes are simply abandoned.
                    state_d   = ST_IDLE;
                    miso_oe_d = 1'b0;
                end else begin
                    if (sck_rise) begin
                        shift_rx_d = {shift_rx_q[5:0], mosi_s};
                        bitcnt_d   = bitcnt_q + 1'b1;
                        byte_done  = (bitcnt_q == '1);
                    end
                    if (sck_fall) begin
                        if (bitcnt_q == '0) begin
                            load_tx = 1'b1;
                        end else begin
                            shift_tx_d = {shift_tx_q[6:0], 1'b1};
                        end
                    end
                end
            end
            ST_WAITHI: begin
                if (nss_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_tx) begin
            tx_pop = 1'b1;
            if (tx_empty) begin
                shift_tx_d = IDLEBYTE;
                unr_d      = 1'b1;
            end else begin
                shift_tx_d = tx_head;
            end
        end

        // A completing byte wins over an acknowledge in the same cycle.
        if (byte_done) begin
            rxd_d     = {shift_rx_q, mosi_s};
            rxvalid_d = 1'b1;
            if (rxvalid_q && !RXRD) begin
                ovr_d = 1'b1;
            end
        end else if (RXRD) begin
            rxvalid_d = 1'b0;
            ovr_d     = 1'b0;
        end

        busy_d = (state_d == ST_ACTIVE);
    end

    // Synchronisers run freely so reset can see the current nSS level.
    always_ff @(posedge CLK) begin
        sck_sync_q  <= sck_sync_d;
        nss_sync_q  <= nss_sync_d;
        mosi_sync_q <= mosi_sync_d;
        shift_rx_q  <= shift_rx_d;
    end

    // Control/output registers; reset lands in WAITHI if selected mid-transfer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= nss_sync_q[S-1] ? ST_IDLE : ST_WAITHI;
            bitcnt_q   <= '0;
            shift_tx_q <= 8'hFF;
            miso_q     <= 1'b1;
            miso_oe_q  <= 1'b0;
            rxd_q      <= 8'h00;
            rxvalid_q  <= 1'b0;
            ovr_q      <= 1'b0;
            unr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_tx_q <= shift_tx_d;
            miso_q     <= shift_tx_q[7];
            miso_oe_q  <= miso_oe_d;
            rxd_q      <= rxd_d;
            rxvalid_q  <= rxvalid_d;
            ovr_q      <= ovr_d;
            unr_q      <= unr_d;
            busy_q     <= busy_d;
        end
    end

    // Drive ports from registered state.
    always_comb begin
        MISO    = miso_q;
        MISO_OE = miso_oe_q;
        TXFULL  = tx_full;
        TXEMPTY = tx_empty;
        RXD     = rxd_q;
        RXVALID = rxvalid_q;
        OVR     = ovr_q;
        UNR     = unr_q;
        BUSY    = busy_q;
    end

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: self-checking bench for spi_target with a queue-based
// model of the TX path (capacity follows SPI_TARGET_TXFIFO_EN).
module tb_spi_target;

`ifdef SPI_TARGET_TXFIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       mosi = 1'b0;
    logic       nss = 1'b1;
    logic       miso, miso_oe, txfull, txempty, rxvalid, ovr, unr, busy;
    logic [7:0] txd = 8'h00;
    logic       txwr = 1'b0;
    logic       rxrd = 1'b0;
    logic [7:0] rxd;

    int         total = 0;
    int         bad = 0;
    logic [7:0] txq[$];
    logic       unr_m = 1'b0;
    logic [7:0] exp_cur = 8'hFF;

    always #5 clk = ~clk;

    spi_target dut (
        .CLK(clk), .RST(rst), .SCK(sck), .MOSI(mosi), .nSS(nss),
        .MISO(miso), .MISO_OE(miso_oe), .TXD(txd), .TXWR(txwr),
        .TXFULL(txfull), .TXEMPTY(txempty), .RXD(rxd), .RXVALID(rxvalid),
        .RXRD(rxrd), .OVR(ovr), .UNR(unr), .BUSY(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Model: bounded queue; an empty pop yields the idle byte and flags underrun.
    function automatic logic [7:0] model_pop();
        logic [7:0] b;
        if (txq.size() > 0) begin
            b = txq.pop_front();
        end else begin
            b = 8'hFF;
            unr_m = 1'b1;
        end
        return b;
    endfunction

    task automatic push(input logic [7:0] b);
        txd = b;
        txwr = 1'b1;
        tick();
        txwr = 1'b0;
        if (txq.size() < CAP) txq.push_back(b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ticks(3);
        rst = 1'b0;
        tick();
        txq.delete();
        unr_m = 1'b0;
    endtask

    task automatic ack();
        rxrd = 1'b1;
        tick();
        rxrd = 1'b0;
        tick();
    endtask

    task automatic select();
        nss = 1'b0;
        ticks(8);
        exp_cur = model_pop();
    endtask

    task automatic deselect();
        nss = 1'b1;
        ticks(8);
    endtask

    // Clock nbits MSB-first; optionally pulse RXRD in the cycle the 8th rise is acted on.
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, input bit coinc,
                            output logic [7:0] mi, output logic rv_early);
        mi = 8'h00;
        rv_early = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            ticks(8);
            mi[7-i] = miso;
            sck = 1'b1;
            if (i == 7) begin
                ticks(2);
                rv_early = rxvalid;
                if (coinc) rxrd = 1'b1;
                tick();
                rxrd = 1'b0;
                ticks(5);
            end else begin
                ticks(8);
            end
            sck = 1'b0;
        end
        ticks(6);
    endtask

    task automatic xfer_byte(input logic [7:0] mo, input bit coinc, output logic [7:0] mi,
                             output logic rv, output logic [7:0] em);
        em = exp_cur;
        spi_xfer(mo, 8, coinc, mi, rv);
        exp_cur = model_pop();
    endtask

    task automatic test_reset();
        string      nm[8] = '{"BUSY", "UNR", "OVR", "RXVALID", "TXEMPTY", "TXFULL", "MISO_OE", "MISO"};
        logic [7:0] exp_v = 8'b1001_0000;
        logic [7:0] obs;
        rst = 1'b1;
        nss = 1'b1;
        ticks(4);
        for (int pass = 0; pass < 2; pass++) begin
            obs = {miso, miso_oe, txfull, txempty, rxvalid, ovr, unr, busy};
            for (int i = 0; i < 8; i++) begin
                total++;
                if (obs[i] !== exp_v[i]) begin bad++; $display("FAIL reset_%s pass%0d got=%b exp=%b", nm[i], pass, obs[i], exp_v[i]); end
            end
            total++;
            if (rxd !== 8'h00) begin bad++; $display("FAIL reset_RXD pass%0d got=%h exp=00", pass, rxd); end
            rst = 1'b0;
            tick();
        end
    endtask

    task automatic test_basic();
        logic [7:0] mi, em;
        logic       rv;
        do_reset();
        push(8'hA5);
        select();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
        total++; if (miso_oe !== 1'b1) begin bad++; $display("FAIL basic_oe got=%b exp=1", miso_oe); end
        push(8'h3C);
        xfer_byte(8'h12, 1'b0, mi, rv, em);
        total++; if (mi !== 8'hA5) begin bad++; $display("FAIL basic_miso1 got=%h exp=a5", mi); end
        total++; if (rv !== 1'b0) begin bad++; $display("FAIL basic_rv_early1 got=%b exp=0", rv); end
        total++; if (rxvalid !== 1'b1) begin bad++; $display("FAIL basic_rxvalid1 got=%b exp=1", rxvalid); end
        total++; if (rxd !== 8'h12) begin bad++; $display("FAIL basic_rxd1 got=%h exp=12", rxd); end
        total++; if (unr !== 1'b0) begin bad++; $display("FAIL basic_unr1 got=%b exp=0", unr); end
        ack();
        xfer_byte(8'h34, 1'b0, mi, rv, em);
        total++; if (mi !== 8'h3C) begin bad++; $display("FAIL basic_miso2 got=%h exp=3c", mi); end
        total++; if (rv !== 1'b0) begin bad++; $display("FAIL basic_rv_early2 got=%b exp=0", rv); end
        total++; if (rxd !== 8'h34) begin bad++; $display("FAIL basic_rxd2 got=%h exp=34", rxd); end
        total++; if (unr !== unr_m) begin bad++; $display("FAIL basic_unr2 got=%b exp=%b", unr, unr_m); end
        ack();
        deselect();
        total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL basic_oe_off got=%b exp=0", miso_oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_off got=%b exp=0", busy); end
    endtask

    task automatic test_underrun();
        logic [7:0] mi, em, b, mo;
        logic       rv;
        do_reset();
        select();
        total++; if (unr !== 1'b1) begin bad++; $display("FAIL unr_flag got=%b exp=1", unr); end
        b = 8'($urandom);
        push(b);
        mo = 8'($urandom);
        xfer_byte(mo, 1'b0, mi, rv, em);
        total++; if (mi !== 8'hFF) begin bad++; $display("FAIL unr_idlebyte got=%h exp=ff", mi); end
        total++; if (rxd !== mo) begin bad++; $display("FAIL unr_rxd got=%h exp=%h", rxd, mo); end
        ack();
        xfer_byte(8'($urandom), 1'b0, mi, rv, em);
        total++; if (mi !== b) begin bad++; $display("FAIL unr_pushed got=%h exp=%h", mi, b); end
        deselect();
        ack();
    endtask

    task automatic test_overrun();
        logic [7:0] mi, em, mo2, mo4;
        logic       rv;
        do_reset();
        select();
        mo2 = 8'($urandom);
        mo4 = 8'($urandom);
        xfer_byte(8'($urandom), 1'b0, mi, rv, em);
        xfer_byte(mo2, 1'b0, mi, rv, em);
        total++; if (ovr !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", ovr); end
        total++; if (rxd !== mo2) begin bad++; $display("FAIL ovr_rxd got=%h exp=%h", rxd, mo2); end
        ack();
        total++; if (rxvalid !== 1'b0) begin bad++; $display("FAIL ovr_ack_rxvalid got=%b exp=0", rxvalid); end
        total++; if (ovr !== 1'b0) begin bad++; $display("FAIL ovr_ack_ovr got=%b exp=0", ovr); end
        xfer_byte(8'($urandom), 1'b0, mi, rv, em);
        xfer_byte(mo4, 1'b1, mi, rv, em);
        total++; if (rxvalid !== 1'b1) begin bad++; $display("FAIL coinc_rxvalid got=%b exp=1", rxvalid); end
        total++; if (ovr !== 1'b0) begin bad++; $display("FAIL coinc_ovr got=%b exp=0", ovr); end
        total++; if (rxd !== mo4) begin bad++; $display("FAIL coinc_rxd got=%h exp=%h", rxd, mo4); end
        deselect();
        ack();
    endtask

    task automatic test_abort();
        logic [7:0] mi, em, b1, mo;
        logic       rv;
        do_reset();
        b1 = 8'($urandom);
        push(b1);
        push(8'($urandom));
        select();
        spi_xfer(8'($urandom), 5, 1'b0, mi, rv);
        total++; if (mi[7:3] !== b1[7:3]) begin bad++; $display("FAIL abort_partial got=%h exp=%h", mi[7:3], b1[7:3]); end
        deselect();
        total++; if (rxvalid !== 1'b0) begin bad++; $display("FAIL abort_rxvalid got=%b exp=0", rxvalid); end
        total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL abort_oe got=%b exp=0", miso_oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        select();
        mo = 8'($urandom);
        xfer_byte(mo, 1'b0, mi, rv, em);
        total++; if (mi !== em) begin bad++; $display("FAIL abort_next got=%h exp=%h", mi, em); end
        total++; if (rxd !== mo) begin bad++; $display("FAIL abort_rxd got=%h exp=%h", rxd, mo); end
        deselect();
        ack();
    endtask

    task automatic test_reset_mid();
        logic [7:0] mi, em, b2, mo;
        logic       rv;
        do_reset();
        push(8'($urandom));
        select();
        spi_xfer(8'($urandom), 3, 1'b0, mi, rv);
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        tick();
        txq.delete();
        unr_m = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL rstmid_oe got=%b exp=0", miso_oe); end
        total++; if (txempty !== 1'b1) begin bad++; $display("FAIL rstmid_txempty got=%b exp=1", txempty); end
        spi_xfer(8'($urandom), 8, 1'b0, mi, rv);
        total++; if (rxvalid !== 1'b0) begin bad++; $display("FAIL waithi_rxvalid got=%b exp=0", rxvalid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL waithi_busy got=%b exp=0", busy); end
        total++; if (unr !== 1'b0) begin bad++; $display("FAIL waithi_unr got=%b exp=0", unr); end
        deselect();
        b2 = 8'($urandom);
        push(b2);
        select();
        mo = 8'($urandom);
        xfer_byte(mo, 1'b0, mi, rv, em);
        total++; if (mi !== b2) begin bad++; $display("FAIL rstmid_new_miso got=%h exp=%h", mi, b2); end
        total++; if (rxd !== mo) begin bad++; $display("FAIL rstmid_new_rxd got=%h exp=%h", rxd, mo); end
        total++; if (rxvalid !== 1'b1) begin bad++; $display("FAIL rstmid_new_rxvalid got=%b exp=1", rxvalid); end
        deselect();
        ack();
    endtask

    task automatic test_capacity();
        logic [7:0] mi, em, bx;
        logic       rv, was_full;
        do_reset();
        for (int i = 0; i < CAP + 1; i++) push(8'($urandom));
        total++; if (txfull !== 1'b1) begin bad++; $display("FAIL cap_full got=%b exp=1", txfull); end
        total++; if (txempty !== 1'b0) begin bad++; $display("FAIL cap_empty got=%b exp=0", txempty); end
        // push lands in the same cycle the select pops the head
        nss = 1'b0;
        ticks(2);
        bx = 8'($urandom);
        txd = bx;
        txwr = 1'b1;
        tick();
        txwr = 1'b0;
        was_full = (txq.size() == CAP);
        exp_cur = model_pop();
        if (!was_full) txq.push_back(bx);
        total++; if (txfull !== (txq.size() == CAP)) begin bad++; $display("FAIL cap_pushpop_full got=%b exp=%b", txfull, txq.size() == CAP); end
        total++; if (txempty !== (txq.size() == 0)) begin bad++; $display("FAIL cap_pushpop_empty got=%b exp=%b", txempty, txq.size() == 0); end
        ticks(5);
        for (int k = 0; k < CAP + 1; k++) begin
            xfer_byte(8'($urandom), 1'b0, mi, rv, em);
            total++; if (mi !== em) begin bad++; $display("FAIL cap_drain%0d got=%h exp=%h", k, mi, em); end
        end
        total++; if (unr !== unr_m) begin bad++; $display("FAIL cap_unr got=%b exp=%b", unr, unr_m); end
        deselect();
        ack();
    endtask

    task automatic test_random();
        logic [7:0] mi, em, mo;
        logic       rv;
        do_reset();
        select();
        for (int n = 0; n < 8; n++) begin
            if ($urandom_range(0, 1) == 1) push(8'($urandom));
            mo = 8'($urandom);
            xfer_byte(mo, 1'b0, mi, rv, em);
            total++; if (mi !== em) begin bad++; $display("FAIL rnd_miso%0d got=%h exp=%h", n, mi, em); end
            total++; if (rxd !== mo) begin bad++; $display("FAIL rnd_rxd%0d got=%h exp=%h", n, rxd, mo); end
            total++; if (unr !== unr_m) begin bad++; $display("FAIL rnd_unr%0d got=%b exp=%b", n, unr, unr_m); end
            total++; if (txempty !== (txq.size() == 0)) begin bad++; $display("FAIL rnd_txempty%0d got=%b exp=%b", n, txempty, txq.size() == 0); end
            ack();
        end
        deselect();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_overrun();
        test_abort();
        test_reset_mid();
        test_capacity();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
